// File: rtl/r_cpu_pkg.sv
// Shared definitions for the R-type CPU result trace: default widths and trace-entry packing.
// Entry layout is {idx, of, zf, data}, most significant field first.
package r_cpu_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_IDX_W  = 8;
  localparam int FLAG_W     = 2;

  typedef struct packed {
    logic [CPU_IDX_W-1:0]  idx;
    logic                  of;
    logic                  zf;
    logic [CPU_DATA_W-1:0] data;
  } trace_entry_t;

  function automatic int entry_width(input int data_w, input int idx_w);
    return idx_w + FLAG_W + data_w;
  endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace FIFO storage: DEPTH x WIDTH register array, one synchronous write port and one
// combinational read port so the head entry falls straight through to the reader.
module trace_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 42
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents carry no reset; validity is tracked by the owning pointers.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/r_cpu_result_trace.sv
// Capture stage for the single-cycle R-type CPU: stores each ALU result with OF/ZF and a wrapping
// instruction index into a first-word-fall-through FIFO drained by a valid/ready pop port.
module r_cpu_result_trace
  import r_cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = CPU_IDX_W
) (
  input  logic                     clka,
  input  logic                     rsta,
  input  logic                     clr,
  input  logic                     cap_en,
  input  logic                     wea,
  input  logic [DATA_W-1:0]        dina,
  input  logic                     ofa,
  input  logic                     zfa,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_of,
  output logic                     rd_zf,
  output logic [IDX_W-1:0]         rd_idx,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic [7:0]               drop_cnt,
  output logic                     overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = entry_width(DATA_W, IDX_W);

  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         drop_q, drop_d;
  logic               ovf_q, ovf_d;

  logic               att, pop, push, drop, empty;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  assign empty    = (count_q == '0);
  assign att      = cap_en & wea;
  assign pop      = ~empty & rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push     = att & (~full_q | pop);
  assign drop     = att & full_q & ~pop;
  assign wr_entry = {idx_q, ofa, zfa, dina};

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    idx_d   = idx_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      idx_d   = '0;
      drop_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (att) begin
        idx_d = idx_q + IDX_W'(1);
      end
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
      end
    end
    full_d = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      idx_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  trace_fifo_mem #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_mem (
    .clk_i  (clka),
    .we_i   (push & ~clr),
    .waddr_i(wptr_q),
    .wdata_i(wr_entry),
    .raddr_i(rptr_q),
    .rdata_o(rd_entry)
  );

  assign rd_valid = ~empty;
  assign rd_data  = empty ? '0 : rd_entry[DATA_W-1:0];
  assign rd_zf    = ~empty & rd_entry[DATA_W];
  assign rd_of    = ~empty & rd_entry[DATA_W+1];
  assign rd_idx   = empty ? '0 : rd_entry[DATA_W+2 +: IDX_W];
  assign count    = count_q;
  assign full     = full_q;
  assign drop_cnt = drop_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_r_cpu_result_trace.sv
// Self-checking bench for r_cpu_result_trace: directed scenarios plus random traffic against a
// queue-based model of the capture FIFO.
module tb_r_cpu_result_trace;

  localparam int DEPTH = 16;

  logic        clka = 1'b0;
  logic        rsta, clr, cap_en, wea, ofa, zfa, rd_ready;
  logic [31:0] dina;
  logic        rd_valid, rd_of, rd_zf, full, overflow;
  logic [31:0] rd_data;
  logic [7:0]  rd_idx, drop_cnt;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  idx;
    logic        of;
    logic        zf;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   m_idx  = 0;
  int   m_drop = 0;
  bit   m_ovf  = 0;

  always #5 clka = ~clka;

  r_cpu_result_trace #(.DATA_W(32), .DEPTH(DEPTH), .IDX_W(8)) dut (
    .clka(clka), .rsta(rsta), .clr(clr), .cap_en(cap_en), .wea(wea),
    .dina(dina), .ofa(ofa), .zfa(zfa), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_of(rd_of), .rd_zf(rd_zf),
    .rd_idx(rd_idx), .count(count), .full(full), .drop_cnt(drop_cnt),
    .overflow(overflow)
  );

  task automatic model_reset();
    mq.delete();
    m_idx  = 0;
    m_drop = 0;
    m_ovf  = 0;
  endtask

  // One clock: drive inputs, advance the model by the behavioural rules, settle 1 time unit.
  task automatic step(input bit cap, input bit we, input logic [31:0] d, input bit o,
                      input bit z, input bit rdy, input bit cl);
    ent_t tmp;
    cap_en = cap; wea = we; dina = d; ofa = o; zfa = z; rd_ready = rdy; clr = cl;
    @(posedge clka);
    if (cl) begin
      model_reset();
    end else begin
      if (rdy && mq.size() > 0) tmp = mq.pop_front();
      if (cap && we) begin
        if (mq.size() < DEPTH) begin
          tmp.idx = 8'(m_idx); tmp.of = o; tmp.zf = z; tmp.data = d;
          mq.push_back(tmp);
        end else begin
          if (m_drop < 255) m_drop++;
          m_ovf = 1;
        end
        m_idx = (m_idx + 1) % 256;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 32'd0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    cap_en = 0; wea = 0; dina = 0; ofa = 0; zfa = 0; rd_ready = 0; clr = 0;
    rsta = 1;
    repeat (2) @(posedge clka);
    #1 rsta = 0;
    model_reset();
    checks++; if (rd_valid !== 1'b0 || count !== 5'd0 || full !== 1'b0) begin
      errors++; $display("FAIL reset_init: valid=%0b count=%0d full=%0b expected 0 0 0", rd_valid, count, full);
    end
    checks++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_init_stats: drop=%0d ovf=%0b expected 0 0", drop_cnt, overflow);
    end
    for (int i = 0; i < 5; i++) step(1, 1, 32'(100 + i), 0, 0, 0, 0);
    checks++; if (count !== 5'd5) begin
      errors++; $display("FAIL reset_prefill: count=%0d expected 5", count);
    end
    cap_en = 0; wea = 0;
    #2 rsta = 1;
    #1;
    checks++; if (rd_valid !== 1'b0 || count !== 5'd0 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_async: valid=%0b count=%0d drop=%0d ovf=%0b expected all 0",
                         rd_valid, count, drop_cnt, overflow);
    end
    #2 rsta = 0;
    model_reset();
    idle();
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) step(1, 1, 32'(i), 0, 0, 0, 0);
    checks++; if (count !== 5'd4) begin
      errors++; $display("FAIL fill_count: got %0d expected 4", count);
    end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (rd_valid !== 1'b1 || rd_data !== 32'(i) || rd_idx !== 8'(i - 1)) begin
        errors++; $display("FAIL drain_%0d: valid=%0b data=%0d idx=%0d expected 1 %0d %0d",
                           i, rd_valid, rd_data, rd_idx, i, i - 1);
      end
      step(0, 0, 32'd0, 0, 0, 1, 0);
    end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 32'd0) begin
      errors++; $display("FAIL drain_empty: valid=%0b data=%0d expected 0 0", rd_valid, rd_data);
    end
    $display("test_fill_drain done");
  endtask

  task automatic test_overflow();
    logic [31:0] last;
    step(0, 0, 32'd0, 0, 0, 0, 1);
    for (int i = 0; i < 18; i++) step(1, 1, $urandom, 0, 0, 0, 0);
    checks++; if (full !== 1'b1 || count !== 5'd16) begin
      errors++; $display("FAIL ovf_full: full=%0b count=%0d expected 1 16", full, count);
    end
    checks++; if (drop_cnt !== 8'd2 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_drop: drop=%0d ovf=%0b expected 2 1", drop_cnt, overflow);
    end
    step(0, 0, 32'd0, 0, 0, 1, 0);
    last = $urandom;
    step(1, 1, last, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 32'd0, 0, 0, 1, 0);
    checks++; if (count !== 5'd1 || rd_idx !== 8'd18 || rd_data !== last) begin
      errors++; $display("FAIL ovf_next_idx: count=%0d idx=%0d data=%h expected 1 18 %h",
                         count, rd_idx, rd_data, last);
    end
    $display("test_overflow done");
  endtask

  task automatic test_full_push_pop();
    step(0, 0, 32'd0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 1, 32'(i), 0, 0, 0, 0);
    step(1, 1, 32'hABCD, 0, 0, 1, 0);
    checks++; if (count !== 5'd16 || full !== 1'b1 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL full_pushpop: count=%0d full=%0b drop=%0d ovf=%0b expected 16 1 0 0",
                         count, full, drop_cnt, overflow);
    end
    checks++; if (rd_idx !== 8'd1 || rd_data !== 32'd1) begin
      errors++; $display("FAIL full_pushpop_head: idx=%0d data=%0d expected 1 1", rd_idx, rd_data);
    end
    $display("test_full_push_pop done");
  endtask

  task automatic test_flags();
    step(0, 0, 32'd0, 0, 0, 0, 1);
    step(1, 1, 32'd0, 0, 1, 0, 0);
    checks++; if (rd_zf !== 1'b1 || rd_of !== 1'b0 || rd_idx !== 8'd0) begin
      errors++; $display("FAIL flag_zf: zf=%0b of=%0b idx=%0d expected 1 0 0", rd_zf, rd_of, rd_idx);
    end
    step(1, 1, 32'h8000_0000, 1, 0, 1, 0);
    checks++; if (rd_of !== 1'b1 || rd_zf !== 1'b0 || rd_idx !== 8'd1 || count !== 5'd1) begin
      errors++; $display("FAIL flag_of: of=%0b zf=%0b idx=%0d count=%0d expected 1 0 1 1",
                         rd_of, rd_zf, rd_idx, count);
    end
    step(1, 0, 32'd7, 0, 0, 1, 0);
    step(0, 1, 32'd8, 0, 0, 0, 0);
    checks++; if (count !== 5'd0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL gate_nopush: count=%0d valid=%0b expected 0 0", count, rd_valid);
    end
    step(1, 1, 32'd9, 0, 0, 0, 0);
    checks++; if (rd_idx !== 8'd2 || rd_data !== 32'd9) begin
      errors++; $display("FAIL gate_idx: idx=%0d data=%0d expected 2 9", rd_idx, rd_data);
    end
    $display("test_flags done");
  endtask

  task automatic test_wrap_sat();
    step(0, 0, 32'd0, 0, 0, 0, 1);
    for (int i = 0; i <= 256; i++) begin
      step(1, 1, 32'(i), 0, 0, 1, 0);
      checks++; if (rd_idx !== 8'(i % 256) || count !== 5'd1) begin
        errors++; $display("FAIL wrap_%0d: idx=%0d count=%0d expected %0d 1", i, rd_idx, count, i % 256);
      end
    end
    step(0, 0, 32'd0, 0, 0, 0, 1);
    for (int i = 0; i < 16 + 300; i++) step(1, 1, $urandom, 0, 0, 0, 0);
    checks++; if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin
      errors++; $display("FAIL drop_sat: drop=%0d ovf=%0b expected 255 1", drop_cnt, overflow);
    end
    step(0, 0, 32'd0, 0, 0, 0, 1);
    checks++; if (count !== 5'd0 || full !== 1'b0 || rd_valid !== 1'b0 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL clr_all: count=%0d full=%0b valid=%0b drop=%0d ovf=%0b expected all 0",
                         count, full, rd_valid, drop_cnt, overflow);
    end
    step(1, 1, 32'd5, 0, 0, 0, 0);
    checks++; if (rd_idx !== 8'd0) begin
      errors++; $display("FAIL clr_idx: idx=%0d expected 0", rd_idx);
    end
    $display("test_wrap_sat done");
  endtask

  task automatic test_random();
    ent_t h;
    step(0, 0, 32'd0, 0, 0, 0, 1);
    for (int n = 0; n < 800; n++) begin
      step(($urandom % 4) != 0, ($urandom % 3) != 0, $urandom, $urandom % 2, $urandom % 2,
           (n % 200 < 100) ? (($urandom % 4) == 0) : (($urandom % 4) != 0), ($urandom % 97) == 0);
      if (mq.size() > 0) h = mq[0];
      else begin h.idx = 0; h.of = 0; h.zf = 0; h.data = 0; end
      checks++; if (rd_valid !== (mq.size() > 0) || count !== 5'(mq.size()) || full !== (mq.size() == DEPTH)) begin
        errors++; $display("FAIL rand_occ_%0d: valid=%0b count=%0d full=%0b expected count %0d",
                           n, rd_valid, count, full, mq.size());
      end
      checks++; if (rd_data !== h.data || rd_idx !== h.idx || rd_of !== h.of || rd_zf !== h.zf) begin
        errors++; $display("FAIL rand_head_%0d: data=%h idx=%0d of=%0b zf=%0b expected %h %0d %0b %0b",
                           n, rd_data, rd_idx, rd_of, rd_zf, h.data, h.idx, h.of, h.zf);
      end
      checks++; if (drop_cnt !== 8'(m_drop) || overflow !== m_ovf) begin
        errors++; $display("FAIL rand_stats_%0d: drop=%0d ovf=%0b expected %0d %0b",
                           n, drop_cnt, overflow, m_drop, m_ovf);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_flags();
    test_wrap_sat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
